// File: rtl/line_window_ctrl_if.sv
// Signal bundle between the pixel source, line_window_ctrl and the line-buffer/window stage.
// master = pixel source / consumer side, slave = line_window_ctrl.
interface line_window_ctrl_if #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
);
   // in_valid/in_ready: a pixel transfers on a rising clk edge where both are 1;
   // in_ready never depends on in_valid, and a stalled source simply holds in_valid low.
   logic             sof;
   logic             in_valid;
   logic             in_ready;
   logic             lb_shift;
   logic             lb_src_sel;
   logic             win_valid;
   logic [COL_W-1:0] win_col;
   logic [ROW_W-1:0] win_row;
   logic             border_top;
   logic             border_bottom;
   logic             border_left;
   logic             border_right;
   logic             eof;
   logic             busy;
   logic             sof_err;

   modport master (
      output sof, in_valid,
      input  in_ready, lb_shift, lb_src_sel, win_valid, win_col, win_row,
             border_top, border_bottom, border_left, border_right, eof, busy, sof_err
   );

   modport slave (
      input  sof, in_valid,
      output in_ready, lb_shift, lb_src_sel, win_valid, win_col, win_row,
             border_top, border_bottom, border_left, border_right, eof, busy, sof_err
   );
endinterface

// File: rtl/line_window_ctrl.sv
// Frame sequencer for the two-line-buffer 3x3 window stage: shift control, window tags, flush row.
// Optional flush row is built when LINE_WINDOW_FLUSH_EN is defined.
module line_window_ctrl #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic              clk,
   input  logic              rst,
   line_window_ctrl_if.slave bus,
   output logic [1:0]        dbg_state
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      ACTIVE = 2'd2
`ifdef LINE_WINDOW_FLUSH_EN
      , FLUSH = 2'd3
`endif
   } state_t;

   state_t           state;
   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic             sof_err_q;

   logic             in_phase;
   logic             flush_phase;
   logic             col_last;
   logic             row_last;
   logic             shift;
   logic             win_v;
   logic             eof_c;
   logic [COL_W-1:0] wcol;
   logic [ROW_W-1:0] wrow;

   // Everything toward the line buffer is combinational so it lines up with the taps of the pixel being shifted.
   always_comb begin
      in_phase = (state == PRIME) || (state == ACTIVE);
`ifdef LINE_WINDOW_FLUSH_EN
      flush_phase = (state == FLUSH);
`else
      flush_phase = 1'b0;
`endif
      col_last = (col_cnt == COL_LAST);
      row_last = (row_cnt == ROW_LAST);
      shift    = (in_phase & bus.in_valid) | flush_phase;
      win_v    = ((state == ACTIVE) & bus.in_valid) | flush_phase;
      wcol     = win_v ? col_cnt : '0;
      wrow     = '0;
      if ((state == ACTIVE) && bus.in_valid)
         wrow = row_cnt - ROW_W'(1);
      else if (flush_phase)
         wrow = ROW_LAST;
`ifdef LINE_WINDOW_FLUSH_EN
      eof_c = flush_phase & col_last;
`else
      eof_c = (state == ACTIVE) & bus.in_valid & col_last & row_last;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         col_cnt   <= '0;
         row_cnt   <= '0;
         sof_err_q <= 1'b0;
      end else if (state == IDLE) begin
         if (bus.sof) begin
            state     <= PRIME;
            col_cnt   <= '0;
            row_cnt   <= '0;
            sof_err_q <= 1'b0;
         end
      end else begin
         // A frame in progress is never restarted; a stray sof only raises the sticky flag.
         if (bus.sof)
            sof_err_q <= 1'b1;
         if (shift) begin
            col_cnt <= col_last ? '0 : col_cnt + COL_W'(1);
            if (col_last)
               row_cnt <= row_cnt + ROW_W'(1);
         end
         case (state)
            PRIME: begin
               if (shift && col_last)
                  state <= ACTIVE;
            end
            ACTIVE: begin
               if (shift && col_last && row_last)
`ifdef LINE_WINDOW_FLUSH_EN
                  state <= FLUSH;
`else
                  state <= IDLE;
`endif
            end
`ifdef LINE_WINDOW_FLUSH_EN
            FLUSH: begin
               if (col_last)
                  state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready      = in_phase;
   assign bus.lb_shift      = shift;
   assign bus.lb_src_sel    = flush_phase;
   assign bus.win_valid     = win_v;
   assign bus.win_col       = wcol;
   assign bus.win_row       = wrow;
   assign bus.border_top    = win_v & (wrow == '0);
   assign bus.border_bottom = win_v & (wrow == ROW_LAST);
   assign bus.border_left   = win_v & (wcol == '0);
   assign bus.border_right  = win_v & (wcol == COL_LAST);
   assign bus.eof           = eof_c;
   assign bus.busy          = (state != IDLE);
   assign bus.sof_err       = sof_err_q;
   assign dbg_state         = state;

endmodule

// File: doc/line_window_ctrl.md
# line_window_ctrl

Frame sequencer for the two-line-buffer 3x3 window datapath in the dehazing pipeline. Accepts a raster pixel stream, drives the line-buffer shift enable and source select, and tags every produced window with its centre coordinates and border flags. At end of frame it runs a flush row so the last image row is emitted as a window centre. Sits between the pixel source and the line-buffer/window stage; downstream filters (dark channel, min filter) use its tags to replicate edge pixels.

## Interface
- IMG_WIDTH, 640, pixels per row (>= 2)
- IMG_HEIGHT, 480, rows per frame (>= 2)
- COL_W, $clog2(IMG_WIDTH), column counter width
- ROW_W, $clog2(IMG_HEIGHT), row counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- sof  in  1  start-of-frame pulse, one cycle
- in_valid  in  1  source pixel present this cycle
- in_ready  out  1  controller accepts a pixel this cycle
- lb_shift  out  1  line-buffer input-valid / shift enable
- lb_src_sel  out  1  0 = source pixel into line buffer, 1 = replicated pixel (flush)
- win_valid  out  1  line-buffer taps form a valid vertical window this cycle
- win_col  out  COL_W  centre column of current window
- win_row  out  ROW_W  centre row of current window
- border_top, border_bottom, border_left, border_right  out  1 each  centre on that image edge
- eof  out  1  one-cycle pulse with the last window of the frame
- busy  out  1  state != IDLE
- sof_err  out  1  sticky: sof received while busy

## Operation
- Registered state: IDLE, PRIME, ACTIVE, FLUSH; registered col_cnt (COL_W), row_cnt (ROW_W), sof_err.
- Accept = in_valid & in_ready. in_ready = 1 in PRIME and ACTIVE, 0 in IDLE and FLUSH.
- lb_shift = accept in PRIME/ACTIVE; constant 1 in FLUSH; 0 in IDLE. lb_src_sel = 1 only in FLUSH.
- col_cnt increments on each lb_shift and wraps IMG_WIDTH-1 -> 0; row_cnt increments on that wrap.
- IDLE: sof -> PRIME, counters cleared. sof_err cleared by an sof accepted in IDLE.
- PRIME (input row 0): no win_valid. On the shift with col_cnt = IMG_WIDTH-1 -> ACTIVE.
- ACTIVE (input rows 1..IMG_HEIGHT-1): win_valid = lb_shift; win_row = row_cnt-1; win_col = col_cnt. On the shift with col_cnt = IMG_WIDTH-1 and row_cnt = IMG_HEIGHT-1 -> FLUSH.
- FLUSH: IMG_WIDTH consecutive cycles, win_valid = 1, win_row = IMG_HEIGHT-1, win_col = col_cnt. On col_cnt = IMG_WIDTH-1 -> IDLE; eof asserted that cycle.
- Borders are combinational from win_row/win_col while win_valid: top = (win_row == 0), bottom = (win_row == IMG_HEIGHT-1), left = (win_col == 0), right = (win_col == IMG_WIDTH-1). All flags are 0 when win_valid = 0.
- sof while busy: ignored (frame continues), sof_err set.
- Gaps in in_valid stall the counters; there is no timeout.

## Timing
- Reset (async assert): state IDLE, counters 0, sof_err 0. All outputs 0, including in_ready, win_* and flags.
- sof at cycle t sets in_ready high at t+1; the first pixel is accepted at t+1 at the earliest.
- lb_shift, win_valid, win_col/row, flags and eof are combinational from registered state/counters and in_valid. They are aligned in the same cycle with the line-buffer taps for the pixel being shifted, with zero added latency.
- A frame of W x H pixels at full rate occupies W*H + W busy cycles and produces W*H win_valid cycles.
- sof on the cycle state returns to IDLE (the eof cycle) is ignored and flagged. sof is accepted only when state = IDLE at the clock edge.
- Reset mid-frame aborts immediately with no eof. Line-buffer contents are not cleared by this block.

## Configuration
- LINE_WINDOW_FLUSH_EN defined: FLUSH state present, behaviour as above.
- Not defined: no FLUSH state; ACTIVE goes directly to IDLE after the last input pixel. eof pulses with that last accepted pixel (win_row = IMG_HEIGHT-2). border_bottom never asserts, lb_src_sel is tied to 0, and a frame yields W*(H-1) windows.

## Test plan
- W=4, H=3, flush enabled, sof then 12 back-to-back pixels -> 4 cycles no win_valid; 8 windows rows 0-1; 4 flush cycles with lb_src_sel=1, win_row=2, border_bottom=1; eof on the 4th flush cycle; 12 win_valid total.
- Same frame with in_valid toggling 1/0 -> identical window sequence and coordinates; counters hold during gaps; in_ready stays 1 until FLUSH.
- Border check on the W=4, H=3 frame -> border_left at win_col 0, border_right at win_col 3, border_top only on row 0 windows; corner (0,0) has top and left set.
- sof pulsed during ACTIVE -> frame completes unchanged and sof_err=1; next sof in IDLE clears sof_err and starts a new frame.
- rst low during ACTIVE at row 1, col 2 -> outputs 0 the same cycle; after release, busy=0; new sof restarts PRIME from (0,0).
- Build without LINE_WINDOW_FLUSH_EN, W=4, H=3 -> 8 windows, eof with the 12th accepted pixel, no lb_src_sel=1, busy drops the next cycle.
